// File: rtl/gan_serial_pkg.sv
// Shared constants, types and helpers for the serial GAN demo.
package gan_serial_pkg;

  localparam int unsigned N_PIXELS = 784;
  localparam int unsigned IDX_W    = 10;
  localparam int unsigned PIX_W    = 16;
  localparam int unsigned ACC_W    = 40;
  localparam int unsigned SCORE_W  = 16;
  localparam int unsigned LFSR_W   = 16;
  localparam int unsigned Q_ONE    = 256;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Feedback taps l[15], l[13], l[12], l[10]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam logic signed [PIX_W-1:0]   W_POS_Q = 16'sd256;
  localparam logic signed [PIX_W-1:0]   W_NEG_Q = -16'sd16;
  localparam logic signed [SCORE_W-1:0] THRESH  = 16'sd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic signed [SCORE_W-1:0] real_score;
    logic signed [SCORE_W-1:0] fake_score;
    logic                      real_is_real;
    logic                      fake_is_real;
  } result_t;

  // Discriminator weight for pixel idx: +1.0 on every 7th pixel, -1/16 elsewhere
  function automatic logic signed [PIX_W-1:0] pixel_weight(input logic [IDX_W-1:0] idx);
    return ((idx % IDX_W'(7)) == IDX_W'(0)) ? W_POS_Q : W_NEG_Q;
  endfunction

  // One step of the Fibonacci LFSR
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

  // Q16.16-ish accumulator to Q8.8 score: arithmetic shift then saturate
  function automatic logic signed [SCORE_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> 8;
    if (sh > 40'sd32767) begin
      return 16'sh7FFF;
    end else if (sh < -40'sd32768) begin
      return 16'sh8000;
    end else begin
      return sh[SCORE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/gan_bit_deserializer.sv
// Captures one real-frame bit per handshake into a 784-bit buffer.
module gan_bit_deserializer
  import gan_serial_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_idle,
  input  logic                i_bit,
  input  logic                i_valid,
  input  logic                i_consume,
  output logic                o_ready,
  output logic                o_frame_ready,
  output logic [N_PIXELS-1:0] o_frame
);

  logic [IDX_W-1:0]    r_count;
  logic                r_frame_ready;
  logic [N_PIXELS-1:0] r_frame;
  logic                w_xfer;

  assign o_ready       = !r_frame_ready && i_idle;
  assign w_xfer        = i_valid && o_ready;
  assign o_frame_ready = r_frame_ready;
  assign o_frame       = r_frame;

  // Store accepted bits in arrival order; flag the frame after the last pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count       <= '0;
      r_frame_ready <= 1'b0;
      r_frame       <= '0;
    end else begin
      if (w_xfer) begin
        r_frame[r_count] <= i_bit;
        if (r_count == IDX_W'(N_PIXELS - 1)) begin
          r_count       <= '0;
          r_frame_ready <= 1'b1;
        end else begin
          r_count <= r_count + IDX_W'(1);
        end
      end else if (i_consume) begin
        r_frame_ready <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gan_serial_system.sv
// Serial GAN demo top: LFSR generator, linear discriminator MAC and result registers.
module gan_serial_system
  import gan_serial_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pixel_bit,
  input  logic                          pixel_bit_valid,
  output logic                          pixel_bit_ready,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          disc_fake_is_real,
  output logic                          disc_real_is_real,
  output logic signed [SCORE_W-1:0]     disc_fake_score,
  output logic signed [SCORE_W-1:0]     disc_real_score,
  output logic [PIX_W*N_PIXELS-1:0]     generated_frame_flat,
  output logic                          generated_frame_valid,
  output logic                          frame_ready
);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic                    w_run_start;
  logic                    w_consume;

  logic [IDX_W-1:0]        r_idx;
  logic [LFSR_W-1:0]       r_lfsr;
  logic signed [ACC_W-1:0] r_acc_fake;
  logic signed [ACC_W-1:0] r_acc_real;
  logic [PIX_W-1:0]        r_gen_pix [N_PIXELS];
  logic                    r_gen_valid;
  result_t                 r_result;
  logic                    r_busy;
  logic                    r_done;

  logic [N_PIXELS-1:0]     w_frame_bits;
  logic                    w_frame_ready;
  logic signed [PIX_W-1:0] w_weight;
  logic signed [ACC_W-1:0] w_pix_ext;
  logic signed [ACC_W-1:0] w_wt_ext;
  logic signed [ACC_W-1:0] w_prod_fake;
  logic signed [ACC_W-1:0] w_prod_real;
  logic signed [SCORE_W-1:0] w_real_score;
  logic signed [SCORE_W-1:0] w_fake_score;

  gan_bit_deserializer u_deser (
    .clk           (clk),
    .rst           (rst),
    .i_idle        (r_state == ST_IDLE),
    .i_bit         (pixel_bit),
    .i_valid       (pixel_bit_valid),
    .i_consume     (w_consume),
    .o_ready       (pixel_bit_ready),
    .o_frame_ready (w_frame_ready),
    .o_frame       (w_frame_bits)
  );

  // MAC operands: unsigned 8-bit generator pixel and signed Q8.8 weight
  assign w_weight     = pixel_weight(r_idx);
  assign w_pix_ext    = ACC_W'({8'h00, r_lfsr[7:0]});
  assign w_wt_ext     = ACC_W'(w_weight);
  assign w_prod_fake  = w_pix_ext * w_wt_ext;
  assign w_prod_real  = w_frame_bits[r_idx] ? (w_wt_ext <<< 8) : '0;
  assign w_real_score = sat16(r_acc_real);
  assign w_fake_score = sat16(r_acc_fake);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and single-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_run_start = 1'b0;
    w_consume   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && w_frame_ready) begin
          w_state_nxt = ST_RUN;
          w_run_start = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_idx == IDX_W'(N_PIXELS - 1)) begin
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (!start) begin
          w_state_nxt = ST_IDLE;
          w_consume   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Generator, accumulators, results and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_lfsr      <= LFSR_SEED;
      r_acc_fake  <= '0;
      r_acc_real  <= '0;
      r_gen_valid <= 1'b0;
      r_result    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int i = 0; i < int'(N_PIXELS); i++) begin
        r_gen_pix[i] <= '0;
      end
    end else begin
      r_busy <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_FIN);
      r_done <= (w_state_nxt == ST_DONE);
      if (w_run_start) begin
        r_idx       <= '0;
        r_lfsr      <= LFSR_SEED;
        r_acc_fake  <= '0;
        r_acc_real  <= '0;
        r_gen_valid <= 1'b0;
      end else if (r_state == ST_RUN) begin
        r_gen_pix[r_idx] <= {8'h00, r_lfsr[7:0]};
        r_acc_fake       <= r_acc_fake + w_prod_fake;
        r_acc_real       <= r_acc_real + w_prod_real;
        r_lfsr           <= lfsr_next(r_lfsr);
        r_idx            <= r_idx + IDX_W'(1);
      end else if (r_state == ST_FIN) begin
        r_result.real_score   <= w_real_score;
        r_result.fake_score   <= w_fake_score;
        r_result.real_is_real <= (w_real_score > THRESH);
        r_result.fake_is_real <= (w_fake_score > THRESH);
        r_gen_valid           <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < int'(N_PIXELS); g++) begin : g_flat
    assign generated_frame_flat[PIX_W*g +: PIX_W] = r_gen_pix[g];
  end

  assign busy                  = r_busy;
  assign done                  = r_done;
  assign frame_ready           = w_frame_ready;
  assign generated_frame_valid = r_gen_valid;
  assign disc_real_score       = r_result.real_score;
  assign disc_fake_score       = r_result.fake_score;
  assign disc_real_is_real     = r_result.real_is_real;
  assign disc_fake_is_real     = r_result.fake_is_real;

endmodule

// File: tb/tb_gan_serial_system.sv
// Scoreboard bench for gan_serial_system with a behavioural frame/score model.
module tb_gan_serial_system;

  localparam int NP = 784;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               pixel_bit = 1'b0;
  logic               pixel_bit_valid = 1'b0;
  logic               pixel_bit_ready;
  logic               start = 1'b0;
  logic               busy;
  logic               done;
  logic               disc_fake_is_real;
  logic               disc_real_is_real;
  logic signed [15:0] disc_fake_score;
  logic signed [15:0] disc_real_score;
  logic [16*NP-1:0]   generated_frame_flat;
  logic               generated_frame_valid;
  logic               frame_ready;

  typedef struct {
    int               real_s;
    int               fake_s;
    bit               real_is;
    bit               fake_is;
    logic [16*NP-1:0] gen;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic done_q  = 1'b0;

  gan_serial_system dut (
    .clk                   (clk),
    .rst                   (rst),
    .pixel_bit             (pixel_bit),
    .pixel_bit_valid       (pixel_bit_valid),
    .pixel_bit_ready       (pixel_bit_ready),
    .start                 (start),
    .busy                  (busy),
    .done                  (done),
    .disc_fake_is_real     (disc_fake_is_real),
    .disc_real_is_real     (disc_real_is_real),
    .disc_fake_score       (disc_fake_score),
    .disc_real_score       (disc_real_score),
    .generated_frame_flat  (generated_frame_flat),
    .generated_frame_valid (generated_frame_valid),
    .frame_ready           (frame_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Floor-divide by 256 and clamp into the signed 16-bit range
  function automatic int score_of(input longint acc);
    longint q;
    if (acc >= 0) q = acc / 256;
    else          q = -((-acc + 255) / 256);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  // Reference: generator pixels from the LFSR sequence, scores as weighted sums
  function automatic exp_t model(input logic [NP-1:0] f);
    exp_t   e;
    longint acc_r = 0;
    longint acc_f = 0;
    int     l = 'hACE1;
    int     p, w, fb;
    e.gen = '0;
    for (int i = 0; i < NP; i++) begin
      p = l % 256;
      w = (i % 7 == 0) ? 256 : -16;
      acc_f += longint'(p * w);
      if (f[i]) acc_r += longint'(256 * w);
      e.gen[16*i +: 16] = 16'(p);
      fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) % 2;
      l  = (l * 2 + fb) % 65536;
    end
    e.real_s  = score_of(acc_r);
    e.fake_s  = score_of(acc_f);
    e.real_is = (e.real_s > 0);
    e.fake_is = (e.fake_s > 0);
    return e;
  endfunction

  // Monitor: on each rising edge of done, pop the expected result and compare
  always @(negedge clk) begin
    exp_t e;
    int   mm;
    if (!rst && done && !done_q) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("real_score", longint'(disc_real_score), longint'(e.real_s));
        chk("fake_score", longint'(disc_fake_score), longint'(e.fake_s));
        chk("real_is_real", disc_real_is_real, e.real_is);
        chk("fake_is_real", disc_fake_is_real, e.fake_is);
        chk("gen_valid", generated_frame_valid, 1);
        mm = 0;
        for (int i = 0; i < NP; i++)
          if (generated_frame_flat[16*i +: 16] !== e.gen[16*i +: 16]) mm++;
        chk("gen_frame_mismatch_cnt", mm, 0);
      end
    end
    done_q = rst ? 1'b0 : done;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pixel_bit_valid = 1'b0;
    start = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, pixel_bit_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_frame_ready"}, frame_ready, 0);
    chk({tag, "_real_score"}, longint'(disc_real_score), 0);
    chk({tag, "_fake_score"}, longint'(disc_fake_score), 0);
    chk({tag, "_flags"}, {disc_real_is_real, disc_fake_is_real}, 0);
    chk({tag, "_gen_valid"}, generated_frame_valid, 0);
    chk({tag, "_gen_zero"}, |generated_frame_flat, 0);
  endtask

  task automatic send_bit(input logic b);
    int guard = 0;
    pixel_bit = b;
    pixel_bit_valid = 1'b1;
    while (!pixel_bit_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) chk("ready_timeout", 0, 1);
    tick();
  endtask

  task automatic send_frame(input logic [NP-1:0] f, input bit gaps);
    for (int i = 0; i < NP; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        pixel_bit_valid = 1'b0;
        pixel_bit = 1'($urandom);
        repeat ($urandom_range(1, 3)) tick();
      end
      if (i == NP - 1) chk("frame_ready_before_last", frame_ready, 0);
      send_bit(f[i]);
    end
    pixel_bit_valid = 1'b0;
    chk("frame_ready_after_last", frame_ready, 1);
    chk("ready_low_after_frame", pixel_bit_ready, 0);
    // Extra bits offered while not ready must be ignored
    pixel_bit_valid = 1'b1;
    pixel_bit = 1'b1;
    repeat (5) tick();
    pixel_bit_valid = 1'b0;
    chk("frame_ready_held", frame_ready, 1);
  endtask

  task automatic run_pass(input logic [NP-1:0] f);
    exp_t e;
    int   cyc = 0;
    int   guard = 0;
    e = model(f);
    sb.push_back(e);
    start = 1'b1;
    do begin
      tick();
      if (busy) cyc++;
      guard++;
    end while (!done && guard < 2000);
    chk("busy_cycles", cyc, 785);
    chk("done_high", done, 1);
    chk("busy_low_in_done", busy, 0);
    repeat (4) tick();
    chk("done_held_with_start", done, 1);
    chk("busy_no_retrigger", busy, 0);
    chk("real_score_stable", longint'(disc_real_score), longint'(e.real_s));
    chk("fake_score_stable", longint'(disc_fake_score), longint'(e.fake_s));
    start = 1'b0;
    tick();
    chk("idle_done_low", done, 0);
    chk("idle_frame_consumed", frame_ready, 0);
    chk("idle_ready_high", pixel_bit_ready, 1);
    chk("gen_valid_held", generated_frame_valid, 1);
  endtask

  logic [NP-1:0] f_pat, f_zero, f_ones, f_rnd;

  initial begin
    for (int i = 0; i < NP; i++) f_pat[i] = (i % 7 == 0);
    f_zero = '0;
    f_ones = '1;

    do_reset();
    check_reset_vals("reset");

    // Pattern frame with valid held continuously
    send_frame(f_pat, 1'b0);
    run_pass(f_pat);
    chk("pattern_real_score_const", longint'(disc_real_score), 28672);
    chk("pattern_real_is_real", disc_real_is_real, 1);
    chk("gen_pixel0", generated_frame_flat[15:0], 16'h00E1);

    // Same frame again: generator must be reseeded
    send_frame(f_pat, 1'b1);
    run_pass(f_pat);

    send_frame(f_zero, 1'b1);
    run_pass(f_zero);
    chk("zero_real_score_const", longint'(disc_real_score), 0);
    chk("zero_real_is_real", disc_real_is_real, 0);

    send_frame(f_ones, 1'b1);
    run_pass(f_ones);
    chk("ones_real_score_const", longint'(disc_real_score), 17920);

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NP; i++) f_rnd[i] = 1'($urandom);
      send_frame(f_rnd, 1'b1);
      run_pass(f_rnd);
    end

    // Reset part-way through a frame
    for (int i = 0; i < 400; i++) send_bit(1'($urandom));
    pixel_bit_valid = 1'b0;
    do_reset();
    check_reset_vals("rst_mid_frame");
    for (int i = 0; i < NP; i++) f_rnd[i] = 1'($urandom);
    send_frame(f_rnd, 1'b1);
    run_pass(f_rnd);

    // Reset part-way through a pass
    send_frame(f_pat, 1'b0);
    start = 1'b1;
    repeat (300) tick();
    chk("busy_mid_run", busy, 1);
    do_reset();
    check_reset_vals("rst_mid_run");
    send_frame(f_ones, 1'b1);
    run_pass(f_ones);

    repeat (5) tick();
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
